// File: rtl/sel_req_arbiter_pkg.sv
// Shared definitions for the request-collection arbiter in front of the
// three-input priority encoder.
package sel_req_arbiter_pkg;

    localparam int unsigned SRC1 = 0;
    localparam int unsigned SRC2 = 1;
    localparam int unsigned SRC3 = 2;

    localparam int unsigned AGE_MAX_DEF = 4;

    typedef enum logic {
        IDLE,
        OFFER
    } state_e;

endpackage

// File: rtl/sel_req_arbiter_age_cnt.sv
// Saturating wait-age counter; clear has priority over increment.
module sel_age_cnt #(
    parameter int unsigned AGE_MAX = 4,
    parameter int unsigned AGE_W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    logic [AGE_W-1:0] cnt_q;
    logic [AGE_W-1:0] cnt_d;

    always_comb begin
        at_max_o = (cnt_q >= AGE_W'(AGE_MAX));
        cnt_d    = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sel_req_arbiter.sv
// Latches request pulses from three sources and offers one at a time
// (one-hot sel1..sel3) with valid/ready, promoting starved sources 2 and 3.
module sel_req_arbiter
    import sel_req_arbiter_pkg::*;
#(
    parameter int unsigned AGE_MAX = AGE_MAX_DEF,
    parameter int unsigned AGE_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_i,
    input  logic       gnt_ready,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       sel_valid,
    output logic [2:0] pend_o
);

    state_e     state_q, state_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] offer_q, offer_d;
    logic [2:0] acc_vec;
    logic       accept;
    logic       inc2, inc3, clr2, clr3, max2, max3;

    function automatic logic [2:0] pick_offer(input logic [2:0] p,
                                              input logic       prom2,
                                              input logic       prom3);
        logic [2:0] o;
        o = '0;
        if (p[SRC2] && prom2) begin
            o[SRC2] = 1'b1;
        end else if (p[SRC3] && prom3) begin
            o[SRC3] = 1'b1;
        end else if (p[SRC1]) begin
            o[SRC1] = 1'b1;
        end else if (p[SRC2]) begin
            o[SRC2] = 1'b1;
        end else if (p[SRC3]) begin
            o[SRC3] = 1'b1;
        end
        return o;
    endfunction

    always_comb begin
        accept  = (state_q == OFFER) && gnt_ready;
        acc_vec = accept ? offer_q : 3'b000;
        pend_d  = (pend_q & ~acc_vec) | req_i;
        clr2    = acc_vec[SRC2];
        clr3    = acc_vec[SRC3];
        inc2    = pend_q[SRC2] && !offer_q[SRC2];
        inc3    = pend_q[SRC3] && !offer_q[SRC3];
        state_d = state_q;
        offer_d = offer_q;
        // A source accepted on this edge has its age cleared, so it must not
        // be promoted again by the age it had before the accept.
        if ((state_q == IDLE) || accept) begin
            if (pend_d != 3'b000) begin
                state_d = OFFER;
                offer_d = pick_offer(pend_d, max2 && !clr2, max3 && !clr3);
            end else begin
                state_d = IDLE;
                offer_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            offer_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            offer_q <= offer_d;
        end
    end

    sel_age_cnt #(.AGE_MAX(AGE_MAX), .AGE_W(AGE_W)) u_age2 (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (inc2),
        .clr_i    (clr2),
        .at_max_o (max2)
    );

    sel_age_cnt #(.AGE_MAX(AGE_MAX), .AGE_W(AGE_W)) u_age3 (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (inc3),
        .clr_i    (clr3),
        .at_max_o (max3)
    );

    assign sel1      = offer_q[SRC1];
    assign sel2      = offer_q[SRC2];
    assign sel3      = offer_q[SRC3];
    assign sel_valid = (state_q == OFFER);
    assign pend_o    = pend_q;

endmodule

// File: tb/tb_sel_req_arbiter.sv
// Bench for sel_req_arbiter: directed scenarios pinned by literals, then
// randomized traffic compared every cycle against a rule-level model.
module tb_sel_req_arbiter;

    localparam int unsigned AGE_MAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_i = '0;
    logic       gnt_ready = 1'b0;
    logic       sel1, sel2, sel3, sel_valid;
    logic [2:0] pend_o;

    int n_chk  = 0;
    int n_fail = 0;

    bit m_pend[3];
    int m_age[3];
    bit m_valid;
    int m_off;
    int m_gnt[3];
    int d_gnt[3];

    sel_req_arbiter #(.AGE_MAX(AGE_MAX), .AGE_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .gnt_ready (gnt_ready),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .sel_valid (sel_valid),
        .pend_o    (pend_o)
    );

    always #5 clk = ~clk;

    // Packed view: {sel3, sel2, sel1, sel_valid, pend[2:0]}
    function automatic logic [6:0] dut_vec();
        return {sel3, sel2, sel1, sel_valid, pend_o};
    endfunction

    function automatic logic [6:0] model_vec();
        logic [6:0] v;
        v = '0;
        if (m_valid) v[4 + m_off] = 1'b1;
        v[3] = m_valid;
        for (int i = 0; i < 3; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_edge(input logic [2:0] req, input bit rdy, input bit r);
        bit acc;
        bit prom[3];
        bit old_p[3];
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_pend[i] = 0;
                m_age[i]  = 0;
            end
            m_valid = 0;
            m_off   = 0;
            return;
        end
        acc = m_valid && rdy;
        for (int i = 0; i < 3; i++) begin
            old_p[i] = m_pend[i];
            prom[i]  = (i != 0) && (m_age[i] >= AGE_MAX) && !(acc && m_off == i);
        end
        if (acc) begin
            m_gnt[m_off]++;
            m_pend[m_off] = 0;
        end
        for (int s = 1; s < 3; s++) begin
            if (acc && m_off == s) m_age[s] = 0;
            else if (old_p[s] && !(m_valid && m_off == s) && m_age[s] < AGE_MAX) m_age[s]++;
        end
        for (int i = 0; i < 3; i++) m_pend[i] = m_pend[i] | req[i];
        if (!m_valid || acc) begin
            m_valid = 1;
            if (m_pend[1] && prom[1]) m_off = 1;
            else if (m_pend[2] && prom[2]) m_off = 2;
            else if (m_pend[0]) m_off = 0;
            else if (m_pend[1]) m_off = 1;
            else if (m_pend[2]) m_off = 2;
            else m_valid = 0;
        end
    endtask

    // Called at a falling edge; applies inputs, lets one rising edge pass,
    // then compares DUT against the model at the next falling edge.
    task automatic step(input logic [2:0] req, input bit rdy, input bit r);
        req_i     = req;
        gnt_ready = rdy;
        rst       = r;
        if (!r && sel_valid === 1'b1 && rdy) begin
            if (sel1) d_gnt[0]++;
            if (sel2) d_gnt[1]++;
            if (sel3) d_gnt[2]++;
        end
        @(posedge clk);
        model_edge(req, rdy, r);
        @(negedge clk);
        n_chk++;
        if (dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL cycle_check t=%0t dut=%b model=%b", $time, dut_vec(), model_vec());
        end
    endtask

    task automatic pin(input string name, input logic [6:0] exp);
        n_chk++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, dut_vec(), exp);
        end
    endtask

    task automatic do_reset();
        step(3'b000, 0, 1);
        step(3'b000, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_gnt[i] = 0;
            d_gnt[i] = 0;
        end
        @(negedge clk);

        // Reset with requests present
        step(3'b111, 0, 1);
        step(3'b111, 0, 1);
        pin("reset_outputs", 7'b000_0_000);
        step(3'b000, 0, 0);
        pin("reset_release_idle", 7'b000_0_000);

        // Single request, held until accepted
        step(3'b100, 0, 0);
        pin("single_offer", 7'b100_1_100);
        step(3'b000, 0, 0);
        step(3'b000, 0, 0);
        pin("single_hold", 7'b100_1_100);
        step(3'b000, 1, 0);
        pin("single_accept_idle", 7'b000_0_000);

        // Priority without preemption
        do_reset();
        step(3'b110, 0, 0);
        pin("prio_offer2", 7'b010_1_110);
        step(3'b001, 0, 0);
        step(3'b000, 0, 0);
        step(3'b000, 0, 0);
        pin("prio_no_preempt", 7'b010_1_111);
        step(3'b000, 1, 0);
        pin("prio_then1", 7'b001_1_101);
        step(3'b000, 1, 0);
        pin("prio_then3", 7'b100_1_100);
        step(3'b000, 1, 0);
        pin("prio_idle", 7'b000_0_000);

        // Starvation promotion of source 3
        do_reset();
        for (int i = 0; i < 5; i++) step(3'b101, 1, 0);
        pin("starve_still1", 7'b001_1_101);
        step(3'b101, 1, 0);
        pin("starve_promote3", 7'b100_1_101);
        step(3'b101, 1, 0);
        pin("starve_resume1", 7'b001_1_101);
        step(3'b000, 1, 0);
        pin("starve_drain3", 7'b100_1_100);
        step(3'b000, 1, 0);
        pin("starve_idle", 7'b000_0_000);

        // Simultaneous accept and re-request
        do_reset();
        step(3'b001, 0, 0);
        pin("rereq_offer1", 7'b001_1_001);
        step(3'b001, 1, 0);
        pin("rereq_no_gap", 7'b001_1_001);
        step(3'b000, 1, 0);
        pin("rereq_idle", 7'b000_0_000);

        // Reset mid-offer with gnt_ready high
        do_reset();
        step(3'b010, 0, 0);
        pin("rst_mid_offer2", 7'b010_1_010);
        step(3'b111, 1, 1);
        pin("rst_mid_dropped", 7'b000_0_000);
        step(3'b000, 1, 0);
        pin("rst_mid_stays_idle", 7'b000_0_000);

        // Randomized traffic: alternate sparse and dense phases
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] rq;
            bit         rd;
            bit         rr;
            if ((i % 600) < 300) begin
                for (int b = 0; b < 3; b++) rq[b] = ($urandom % 4) == 0;
                rd = ($urandom % 3) != 0;
            end else begin
                for (int b = 0; b < 3; b++) rq[b] = ($urandom % 4) != 0;
                rd = ($urandom % 8) != 0;
            end
            rr = ($urandom % 250) == 0;
            step(rq, rd, rr);
        end

        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (d_gnt[i] != m_gnt[i]) begin
                n_fail++;
                $display("FAIL grant_count_src%0d got=%0d expected=%0d", i + 1, d_gnt[i], m_gnt[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sel_req_arbiter.md
# sel_req_arbiter

Upstream request-collection stage for the three-input priority encoder (`sel1`/`sel2`/`sel3` → 2-bit code).
- Latches asynchronous-in-time request pulses from three sources and offers exactly one of them at a time on `sel1..sel3`, with a valid/ready handshake.
- Adds starvation promotion, so that sources 2 and 3 cannot be locked out by the fixed priority (1 > 2 > 3) of the downstream encoder.
- Sits directly in front of the encoder; the consumer of the encoder's code returns `gnt_ready`.

## Interface
- `AGE_MAX`, default 4: wait cycles after which a pending source 2 or 3 is promoted; legal range 1..2^`AGE_W`−1.
- `AGE_W`, default 3: width of each age counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_i`  in  3  request pulses; bit0 = source 1, bit1 = source 2, bit2 = source 3; sampled every edge.
- `gnt_ready`  in  1  downstream accepts the current offer this cycle.
- `sel1`, `sel2`, `sel3`  out  1 each  offered source, one-hot; all 0 when `sel_valid` = 0.
- `sel_valid`  out  1  an offer is present.
- `pend_o`  out  3  pending-request register (debug/status).

## Operation
- **Pending register:**
  - `pending` |= `req_i` at every edge.
  - Repeated requests from an already-pending source merge; they are not counted.
- **Accept:** occurs on an edge with `sel_valid` && `gnt_ready`. It clears the offered source's pending bit and age counter.
- **Simultaneous accept and new request, same source:** the request wins and the bit stays 1, as a new request.
- **FSM, two states:**
  - IDLE: `sel_valid` = 0. Moves to OFFER when (`pending` | `req_i`) ≠ 0, loading the offer at that edge.
  - OFFER: `sel_valid` = 1 and the offer is held stable until accepted.
    - On accept: if the remaining pending bits, including same-edge arrivals, are ≠ 0, stay in OFFER and reload the offer at that edge; otherwise go to IDLE.
- **No preemption:** a higher-priority request arriving during OFFER does not change the current offer.
- **Offer selection**, evaluated on (`pending` after clear) | `req_i`, first match wins:
  1. Source 2, if pending and age2 ≥ `AGE_MAX`.
  2. Source 3, if pending and age3 ≥ `AGE_MAX`.
  3. Source 1.
  4. Source 2.
  5. Source 3.
- **Age counters** (sources 2 and 3 only):
  - Increment at each edge where the source is pending and not the current offer.
  - Saturate at `AGE_MAX`.
  - Clear on accept of that source.
  - Ages are not reset by a source merely being offered; only acceptance clears them.
- Source 1 has no age counter; it is never starved under the promotion rule, because promotion serves at most one source per accept.

## Timing
- **Latency:** `req_i` high before edge k in IDLE → `sel_valid` = 1 with that source's `selN` in the cycle after edge k (1 cycle).
- **Back-to-back:** an accept at edge k with further pending requests → the new offer is valid in the cycle after edge k, with no bubble.
- **Throughput:** one grant per cycle when `gnt_ready` is held at 1.
- **Reset values** (after a `rst` edge): `pending` = 0, ages = 0, state IDLE, `sel1..3` = 0, `sel_valid` = 0, `pend_o` = 0.
- **Reset mid-offer:** the offer is dropped and no accept occurs, even if `gnt_ready` = 1 on that edge. `req_i` on the reset edge is ignored.
- `gnt_ready` while `sel_valid` = 0 has no effect.

## Structure
- **Shared package:**
  - Source index constants: `SRC1` = 0, `SRC2` = 1, `SRC3` = 2.
  - State enum {IDLE, OFFER}.
  - Default `AGE_MAX`.
- **Sub-module:** `sel_age_cnt`, a saturating counter with inc/clr inputs and an `at_max` output, instantiated twice (sources 2 and 3).
- Offer selection is a combinational function in the top level; `sel1..3` are driven straight from the offer register.

## Test plan
All scenarios use `AGE_MAX` = 4.
- **Reset:** assert `rst` for 2 cycles with `req_i` = 3'b111 → all outputs 0. After release with `req_i` = 0, `sel_valid` stays 0.
- **Single request:** pulse `req_i` = 3'b100 for 1 cycle with `gnt_ready` = 0 → next cycle `sel3` = 1, `sel_valid` = 1, held. Raise `gnt_ready` → accept, then IDLE and `pend_o` = 0.
- **Priority without preemption:** `req_i` = 3'b110 → `sel2` is offered. The following cycle `req_i` = 3'b001 with `gnt_ready` = 0 for 3 cycles → `sel2` is held. After accept, `sel1` is offered, then `sel3`.
- **Starvation promotion:** hold `req_i` = 3'b101 with `gnt_ready` = 1 → `sel1` is granted every cycle until age3 reaches 4. Then `sel3` is offered, after which `sel1` resumes.
- **Simultaneous accept and re-request:** source 1 is offered; at the accepting edge, `req_i` = 3'b001 → `pend_o`[0] stays 1 and `sel1` is re-offered with no gap.
- **Reset mid-offer:** `sel2` is offered; `rst` and `gnt_ready` are asserted on the same edge → `sel_valid` = 0, `pend_o` = 0, and no grant is observed by the bench scoreboard.
